// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bundle for cla_addsub_pipe: valid/ready request side plus
// valid/ready result side with sum and status flags.
interface cla_addsub_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;
  logic             zero;
  logic             neg;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, sum, cout, ovfl, zero, neg
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovfl, zero, neg
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with optional saturation.
// GROUP-bit CLA slices, carry chain split across STAGES register stages.
module cla_addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  cla_addsub_pipe_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / GROUP;
  localparam int unsigned SPS    = NSLICE / STAGES;
  localparam int unsigned BPS    = GROUP * SPS;
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] raw;
    logic             c;
    logic [1:0]       op;
  } stage_t;

  logic [1:0]        rst_sync_q;
  logic              rst_int_n;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] adv;
  stage_t            src   [STAGES];
  stage_t            stg_d [STAGES];
  stage_t            stg_q [STAGES];
  stage_t            fin;
  logic [WIDTH-1:0]  sum_d, sum_q;
  logic              cout_d, cout_q;
  logic              ovfl_d, ovfl_q;
  logic              zero_d, zero_q;
  logic              neg_d, neg_q;

  // Carries of one slice in sum-of-products lookahead form.
  function automatic logic [GROUP:0] cla_carries(
    input logic [GROUP-1:0] g,
    input logic [GROUP-1:0] p,
    input logic             c0
  );
    logic [GROUP:0] c;
    logic           t;
    logic           pr;
    c    = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < GROUP; i++) begin
      t  = 1'b0;
      pr = 1'b1;
      for (int unsigned j = 0; j <= i; j++) begin
        t  = t | (g[i-j] & pr);
        pr = pr & p[i-j];
      end
      c[i+1] = t | (c0 & pr);
    end
    return c;
  endfunction

  // Asynchronous assert, clock-synchronous release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    vin = '0;
    ld  = '0;
    adv = '0;
    vin[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) vin[k] = v_q[k-1];
    adv[STAGES-1] = bus.out_ready;
    ld[STAGES-1]  = ~v_q[STAGES-1] | adv[STAGES-1];
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = ld[STAGES-i];
      ld[STAGES-1-i]  = ~v_q[STAGES-1-i] | adv[STAGES-1-i];
    end
  end

  assign bus.in_ready = ld[0] & rst_int_n;

  // Each stage fills its own bit window; higher bits pass through untouched.
  always_comb begin
    stage_t           st;
    logic             cy;
    logic [GROUP-1:0] ga;
    logic [GROUP-1:0] gb;
    logic [GROUP:0]   cc;
    int unsigned      lo;
    st = '0;
    cy = 1'b0;
    ga = '0;
    gb = '0;
    cc = '0;
    lo = 0;
    src[0].a   = bus.a;
    src[0].bi  = bus.op[0] ? ~bus.b : bus.b;
    src[0].raw = '0;
    src[0].c   = bus.op[0];
    src[0].op  = bus.op;
    for (int unsigned k = 1; k < STAGES; k++) src[k] = stg_q[k-1];
    for (int unsigned k = 0; k < STAGES; k++) begin
      st = src[k];
      cy = st.c;
      for (int unsigned s = 0; s < SPS; s++) begin
        lo = k * BPS + s * GROUP;
        ga = st.a[lo +: GROUP];
        gb = st.bi[lo +: GROUP];
        cc = cla_carries(ga & gb, ga ^ gb, cy);
        st.raw[lo +: GROUP] = ga ^ gb ^ cc[GROUP-1:0];
        cy = cc[GROUP];
      end
      st.c     = cy;
      stg_d[k] = st;
    end
  end

  always_comb begin
    fin    = stg_d[STAGES-1];
    ovfl_d = (fin.a[WIDTH-1] == fin.bi[WIDTH-1]) & (fin.raw[WIDTH-1] != fin.a[WIDTH-1]);
    cout_d = fin.c;
    if (fin.op[1] && ovfl_d) sum_d = fin.a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    else                     sum_d = fin.raw;
    zero_d = (sum_d == '0);
    neg_d  = sum_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      v_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovfl_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) stg_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          v_q[k] <= vin[k];
          if (vin[k]) stg_q[k] <= stg_d[k];
        end
      end
      if (ld[STAGES-1] && vin[STAGES-1]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovfl_q <= ovfl_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
      end
    end
  end

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovfl      = ovfl_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: directed cases on a 16-bit/2-stage
// instance, random traffic on 32-bit 4-stage and 1-stage instances.
`timescale 1ns/1ps
module tb_cla_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  cla_addsub_pipe_if #(.WIDTH(16)) b16 ();
  cla_addsub_pipe_if #(.WIDTH(32)) b4 ();
  cla_addsub_pipe_if #(.WIDTH(32)) b1 ();

  cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .STAGES(2)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(4)) u32s4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(1)) u32s1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic        strict;
  logic [63:0] exp16;
  logic [63:0] q16[$], q4[$], q1[$];
  int          t16[$], t4[$], t1[$];
  int          n_pop16 = 0;
  logic [63:0] e16, e4, e1, held;
  int          tt16, tt4, tt1;
  logic [31:0] ra, rb;
  logic [1:0]  rop;
  int          base;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic, result packed as {sum, cout, ovfl, zero, neg}.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] op, input int w);
    logic [63:0] m, av, bi, full, raw, s;
    logic c, o, z, n;
    int msb;
    msb  = w - 1;
    m    = (64'd1 << w) - 64'd1;
    av   = {32'b0, a} & m;
    bi   = op[0] ? (~{32'b0, b}) & m : {32'b0, b} & m;
    full = av + bi + {63'b0, op[0]};
    raw  = full & m;
    c    = full[w];
    o    = (av[msb] == bi[msb]) && (raw[msb] != av[msb]);
    if (op[1] && o) s = av[msb] ? (64'd1 << msb) : (m >> 1);
    else            s = raw;
    z = (s == 64'd0);
    n = s[msb];
    return (s << 4) | {60'b0, c, o, z, n};
  endfunction

  function automatic logic [63:0] pk16(input logic [15:0] s, input logic c, input logic o,
                                       input logic z, input logic n);
    return {44'b0, s, c, o, z, n};
  endfunction

  function automatic logic [63:0] obs16();
    return {44'b0, b16.sum, b16.cout, b16.ovfl, b16.zero, b16.neg};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] edges [8];
    edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000,
              32'hFFFF_FFFF, 32'h0000_7FFF, 32'h0000_8000, 32'h0000_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      t16.delete();
    end else begin
      if (b16.out_valid && b16.out_ready) begin
        check_eq("u16 pending", 64'(q16.size() > 0), 64'd1);
        if (q16.size() > 0) begin
          e16  = q16.pop_front();
          tt16 = t16.pop_front();
          check_eq("u16 result", obs16(), e16);
          if (strict) check_eq("u16 latency", 64'(cyc - tt16), 64'd2);
          n_pop16++;
        end
      end
      if (b16.in_valid && b16.in_ready) begin
        q16.push_back(exp16);
        t16.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      t4.delete();
    end else begin
      if (b4.out_valid && b4.out_ready) begin
        check_eq("u32s4 pending", 64'(q4.size() > 0), 64'd1);
        if (q4.size() > 0) begin
          e4  = q4.pop_front();
          tt4 = t4.pop_front();
          check_eq("u32s4 result", {28'b0, b4.sum, b4.cout, b4.ovfl, b4.zero, b4.neg}, e4);
          if (strict) check_eq("u32s4 latency", 64'(cyc - tt4), 64'd4);
        end
      end
      if (b4.in_valid && b4.in_ready) begin
        q4.push_back(model(b4.a, b4.b, b4.op, 32));
        t4.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      t1.delete();
    end else begin
      if (b1.out_valid && b1.out_ready) begin
        check_eq("u32s1 pending", 64'(q1.size() > 0), 64'd1);
        if (q1.size() > 0) begin
          e1  = q1.pop_front();
          tt1 = t1.pop_front();
          check_eq("u32s1 result", {28'b0, b1.sum, b1.cout, b1.ovfl, b1.zero, b1.neg}, e1);
          if (strict) check_eq("u32s1 latency", 64'(cyc - tt1), 64'd1);
        end
      end
      if (b1.in_valid && b1.in_ready) begin
        q1.push_back(model(b1.a, b1.b, b1.op, 32));
        t1.push_back(cyc);
      end
    end
  end

  task automatic set_idle();
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.op = '0; b16.out_ready = 1'b1;
    b4.in_valid  = 1'b0; b4.a  = '0; b4.b  = '0; b4.op  = '0; b4.out_ready  = 1'b1;
    b1.in_valid  = 1'b0; b1.a  = '0; b1.b  = '0; b1.op  = '0; b1.out_ready  = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic [63:0] e);
    int n;
    b16.in_valid = 1'b1;
    b16.a        = a;
    b16.b        = b;
    b16.op       = op;
    exp16        = e;
    n            = 0;
    @(negedge clk);
    while (!b16.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("u16 accept", 64'(b16.in_ready), 64'd1);
    @(posedge clk);
    #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic rnd_step(input bit stall);
    logic [31:0] a, b;
    logic [1:0]  op;
    logic        iv, orr;
    a   = pick();
    b   = pick();
    op  = 2'($urandom_range(0, 3));
    iv  = ($urandom_range(0, 9) < 8);
    orr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    b16.in_valid = iv; b16.a = a[15:0]; b16.b = b[15:0]; b16.op = op; b16.out_ready = orr;
    exp16 = model(a, b, op, 16);
    b4.in_valid = iv; b4.a = a; b4.b = b; b4.op = op; b4.out_ready = orr;
    b1.in_valid = iv; b1.a = a; b1.b = b; b1.op = op; b1.out_ready = orr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    strict = 1'b1;
    exp16  = '0;
    set_idle();
    repeat (3) @(negedge clk);
    check_eq("reset out_valid u16", 64'(b16.out_valid), 64'd0);
    check_eq("reset out_valid u32s4", 64'(b4.out_valid), 64'd0);
    check_eq("reset out_valid u32s1", 64'(b1.out_valid), 64'd0);
    check_eq("reset outputs u16", obs16(), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    send16(16'h1234, 16'h0001, 2'b00, pk16(16'h1235, 1'b0, 1'b0, 1'b0, 1'b0));
    send16(16'h0005, 16'h0005, 2'b01, pk16(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    send16(16'h0000, 16'h0001, 2'b01, pk16(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1));
    send16(16'h7FFF, 16'h0001, 2'b00, pk16(16'h8000, 1'b0, 1'b1, 1'b0, 1'b1));
    send16(16'h7FFF, 16'h0001, 2'b10, pk16(16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0));
    send16(16'h8000, 16'h0001, 2'b11, pk16(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
    send16(16'h8000, 16'h0001, 2'b01, pk16(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0));
    send16(16'h8000, 16'hFFFF, 2'b10, pk16(16'h8000, 1'b1, 1'b1, 1'b0, 1'b1));
    send16(16'h0001, 16'h0002, 2'b10, pk16(16'h0003, 1'b0, 1'b0, 1'b0, 1'b0));
    send16(16'hFFFF, 16'h0001, 2'b00, pk16(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    check_eq("directed count", 64'(n_pop16), 64'd10);

    strict = 1'b0;
    base   = n_pop16;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra  = $urandom;
          rb  = $urandom;
          rop = 2'($urandom_range(0, 3));
          send16(ra[15:0], rb[15:0], rop, model(ra, rb, rop, 16));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        b16.out_ready = 1'b0;
        @(negedge clk);
        held = obs16();
        check_eq("stall out_valid", 64'(b16.out_valid), 64'd1);
        check_eq("stall in_ready full", 64'(b16.in_ready), 64'd0);
        for (int i = 0; i < 2; i++) begin
          @(negedge clk);
          check_eq("stall out_valid", 64'(b16.out_valid), 64'd1);
          check_eq("stall in_ready full", 64'(b16.in_ready), 64'd0);
          check_eq("stall hold", obs16(), held);
        end
        @(posedge clk);
        #1;
        b16.out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check_eq("stream count", 64'(n_pop16 - base), 64'd8);
    check_eq("stream drained", 64'(q16.size()), 64'd0);

    b16.out_ready = 1'b0;
    send16(16'h1111, 16'h2222, 2'b00, pk16(16'h3333, 1'b0, 1'b0, 1'b0, 1'b0));
    send16(16'h4444, 16'h1111, 2'b01, pk16(16'h3333, 1'b1, 1'b0, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("reset flush out_valid", 64'(b16.out_valid), 64'd0);
    check_eq("reset flush outputs", obs16(), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b16.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("no stale after reset", 64'(b16.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    strict = 1'b1;
    send16(16'h00FF, 16'hFF01, 2'b00, pk16(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 6000; i++) rnd_step(1'b0);
    strict = 1'b0;
    for (int i = 0; i < 9000; i++) rnd_step(1'b1);
    set_idle();
    repeat (10) @(posedge clk);
    #1;
    check_eq("final drain u16", 64'(q16.size()), 64'd0);
    check_eq("final drain u32s4", 64'(q4.size()), 64'd0);
    check_eq("final drain u32s1", 64'(q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
